// File: rtl/match_eliminate.sv
// match_eliminate: clears every run of >= MIN_RUN equal non-empty cells; result 2N+1 cycles after start, start ignored while busy.
// Optional MATCH_SCORE_EN builds the saturating score accumulator (score tied to 0 otherwise).
module match_eliminate #(
    parameter int N       = 8,
    parameter int W       = 3,
    parameter int MIN_RUN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N*N*W-1:0] board_in,
    output logic             busy,
    output logic             done,
    output logic [N*N*W-1:0] board_out,
    output logic [N*N-1:0]   clear_mask,
    output logic             match_found,
    output logic [6:0]       cleared_count,
    output logic [15:0]      score
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN_H,
        S_SCAN_V,
        S_COMMIT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IW-1:0]      r_idx;
    logic [N*N*W-1:0]   r_snap;
    logic [N*N-1:0]     r_mask;

    logic               w_last;
    logic               w_accept;
    logic               w_scan;
    logic               w_commit;
    logic [W-1:0]       w_line [N];
    logic [N-2:0]       w_eq;
    logic [N-1:0]       w_mark;
    logic               w_win;
    logic [N*N-1:0]     w_mask_nxt;
    logic [6:0]         w_popcnt;
    logic [N*N*W-1:0]   w_board_clr;

    assign w_last   = (r_idx == IW'(N - 1));
    assign w_accept = (r_state == S_IDLE) && start;
    assign w_scan   = (r_state == S_SCAN_H) || (r_state == S_SCAN_V);
    assign w_commit = (r_state == S_COMMIT);
    assign busy     = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start)  w_state_nxt = S_SCAN_H;
            S_SCAN_H: if (w_last) w_state_nxt = S_SCAN_V;
            S_SCAN_V: if (w_last) w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // The indexed row (SCAN_H) or column (SCAN_V) presented as one line of N cells.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            if (r_state == S_SCAN_V) begin
                w_line[j] = r_snap[(j*N + int'(r_idx))*W +: W];
            end else begin
                w_line[j] = r_snap[(int'(r_idx)*N + j)*W +: W];
            end
        end
    end

    // A cell is marked when some MIN_RUN-wide window covering it is all equal and non-zero;
    // the union of such windows is exactly the set of maximal runs >= MIN_RUN.
    always_comb begin
        w_eq   = '0;
        w_mark = '0;
        w_win  = 1'b0;
        for (int j = 0; j < N - 1; j++) begin
            w_eq[j] = (w_line[j] != '0) && (w_line[j] == w_line[j+1]);
        end
        for (int s = 0; s <= N - MIN_RUN; s++) begin
            w_win = 1'b1;
            for (int k = 0; k < MIN_RUN - 1; k++) begin
                w_win = w_win & w_eq[s+k];
            end
            if (w_win) begin
                for (int k = 0; k < MIN_RUN; k++) begin
                    w_mark[s+k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_mask_nxt = r_mask;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if ((r_state == S_SCAN_H && int'(r_idx) == r && w_mark[c]) ||
                    (r_state == S_SCAN_V && int'(r_idx) == c && w_mark[r])) begin
                    w_mask_nxt[r*N + c] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_popcnt    = '0;
        w_board_clr = r_snap;
        for (int k = 0; k < N*N; k++) begin
            w_popcnt = w_popcnt + {6'd0, r_mask[k]};
            if (r_mask[k]) begin
                w_board_clr[k*W +: W] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx         <= '0;
            r_snap        <= '0;
            r_mask        <= '0;
            done          <= 1'b0;
            board_out     <= '0;
            clear_mask    <= '0;
            match_found   <= 1'b0;
            cleared_count <= '0;
        end else begin
            done <= w_commit;
            if (w_accept) begin
                r_snap <= board_in;
                r_mask <= '0;
                r_idx  <= '0;
            end else if (w_scan) begin
                r_mask <= w_mask_nxt;
                r_idx  <= w_last ? '0 : r_idx + 1'b1;
            end
            if (w_commit) begin
                board_out     <= w_board_clr;
                clear_mask    <= r_mask;
                match_found   <= |r_mask;
                cleared_count <= w_popcnt;
            end
        end
    end

`ifdef MATCH_SCORE_EN
    logic [7:0]  r_runs;
    logic [15:0] r_score;
    logic [3:0]  w_line_runs;
    logic        w_long;
    logic [16:0] w_score_sum;

    // Count each maximal run of >= MIN_RUN+1 once, at its first cell.
    always_comb begin
        w_line_runs = '0;
        w_long      = 1'b0;
        for (int s = 0; s <= N - 1 - MIN_RUN; s++) begin
            w_long = (s == 0) || !w_eq[(s > 0) ? s - 1 : 0];
            for (int k = 0; k < MIN_RUN; k++) begin
                w_long = w_long & w_eq[s+k];
            end
            w_line_runs = w_line_runs + {3'd0, w_long};
        end
    end

    assign w_score_sum = {1'b0, r_score} + 17'(w_popcnt) + 17'({r_runs, 1'b0});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_runs  <= '0;
            r_score <= '0;
        end else begin
            if (w_accept) begin
                r_runs <= '0;
            end else if (w_scan) begin
                r_runs <= r_runs + 8'(w_line_runs);
            end
            if (w_commit) begin
                r_score <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
            end
        end
    end

    assign score = r_score;
`else
    assign score = '0;
`endif

endmodule

// File: tb/tb_match_eliminate.sv
// Directed bench for match_eliminate: hand-built boards, expected masks/counts/score written out per case.
module tb_match_eliminate;

    localparam int N  = 8;
    localparam int W  = 3;
    localparam int NB = N*N*W;
    typedef logic [NB-1:0] board_t;

`ifdef MATCH_SCORE_EN
    localparam bit SCORE_ON = 1'b1;
`else
    localparam bit SCORE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    board_t      board_in = '0;
    logic        busy;
    logic        done;
    board_t      board_out;
    logic [63:0] clear_mask;
    logic        match_found;
    logic [6:0]  cleared_count;
    logic [15:0] score;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_score = '0;

    match_eliminate #(.N(N), .W(W), .MIN_RUN(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .board_in      (board_in),
        .busy          (busy),
        .done          (done),
        .board_out     (board_out),
        .clear_mask    (clear_mask),
        .match_found   (match_found),
        .cleared_count (cleared_count),
        .score         (score)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checkerboard of colours 1/2: no two neighbours equal, so no runs.
    function automatic board_t base_board();
        board_t b = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                b[(r*N+c)*W +: W] = ((r + c) % 2 == 0) ? 3'd1 : 3'd2;
        return b;
    endfunction

    function automatic board_t put(input board_t b, input int r, input int c, input logic [2:0] v);
        board_t t = b;
        t[(r*N+c)*W +: W] = v;
        return t;
    endfunction

    function automatic board_t zap(input board_t b, input logic [63:0] m);
        board_t t = b;
        for (int k = 0; k < N*N; k++)
            if (m[k]) t[k*W +: W] = 3'd0;
        return t;
    endfunction

    task automatic launch(input board_t b);
        @(negedge clk);
        board_in = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
    endtask

    task automatic run_and_check(input string tag, input board_t b, input logic [63:0] m,
                                 input int cnt, input int bonus);
        int cyc;
        launch(b);
        chk({tag, " busy"}, busy, 1);
        wait_done(cyc);
        chk({tag, " latency"}, cyc, 17);
        chk({tag, " busy at done"}, busy, 0);
        chk({tag, " mask"}, clear_mask, m);
        chk({tag, " count"}, cleared_count, cnt);
        chk({tag, " match_found"}, match_found, (m != 64'd0));
        chk({tag, " board_out"}, board_out, zap(b, m));
        if (SCORE_ON) exp_score = exp_score + 16'(cnt + bonus);
        chk({tag, " score"}, score, exp_score);
        @(negedge clk);
        chk({tag, " done width"}, done, 0);
    endtask

    initial begin
        board_t b_single, b_t, b_empty, b_edge, b_full;
        logic [63:0] m_single, m_t;
        int cyc, pulses;

        b_single = base_board();
        for (int c = 3; c <= 5; c++) b_single = put(b_single, 2, c, 3'd4);
        m_single = (64'd1 << 19) | (64'd1 << 20) | (64'd1 << 21);

        b_t = base_board();
        for (int c = 0; c <= 4; c++) b_t = put(b_t, 0, c, 3'd5);
        for (int r = 0; r <= 3; r++) b_t = put(b_t, r, 2, 3'd5);
        m_t = 64'h1F | (64'd1 << 10) | (64'd1 << 18) | (64'd1 << 26);

        b_empty = base_board();
        for (int c = 0; c < N; c++) b_empty = put(b_empty, 4, c, 3'd0);

        b_edge = put(put(put(base_board(), 0, 6, 3'd3), 0, 7, 3'd3), 1, 0, 3'd3);

        b_full = '0;
        for (int k = 0; k < N*N; k++) b_full[k*W +: W] = 3'd7;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst board_out", board_out, 0);
        chk("rst mask", clear_mask, 0);
        chk("rst count", cleared_count, 0);
        chk("rst match", match_found, 0);
        chk("rst score", score, 0);
        rst = 1'b0;

        run_and_check("single", b_single, m_single, 3, 0);
        run_and_check("tshape", b_t, m_t, 8, 4);
        run_and_check("nomatch", base_board(), 64'd0, 0, 0);
        run_and_check("zero_row", b_empty, 64'd0, 0, 0);

        // Reset during SCAN_V: outputs drop at once, no done, then a full pass works
        launch(b_single);
        repeat (11) @(negedge clk);
        chk("midrst busy before", busy, 1);
        rst = 1'b1;
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst board_out", board_out, 0);
        chk("midrst mask", clear_mask, 0);
        chk("midrst count", cleared_count, 0);
        chk("midrst match", match_found, 0);
        chk("midrst score", score, 0);
        exp_score = '0;
        @(negedge clk);
        rst = 1'b0;
        count_done(25, pulses);
        chk("midrst no done", pulses, 0);
        run_and_check("after_rst", b_single, m_single, 3, 0);

        // Edge/no-wrap board; second start and board_in change mid-pass must be ignored
        launch(b_edge);
        repeat (4) @(negedge clk);
        start    = 1'b1;
        board_in = b_full;
        @(negedge clk);
        start    = 1'b0;
        wait_done(cyc);
        chk("edge latency", cyc + 5, 17);
        chk("edge mask", clear_mask, 0);
        chk("edge count", cleared_count, 0);
        chk("edge board_out", board_out, b_edge);
        chk("edge score", score, exp_score);
        count_done(25, pulses);
        chk("edge single done", pulses, 0);
        chk("edge idle", busy, 0);

        // Full board, start held high: back-to-back passes
        @(negedge clk);
        board_in = b_full;
        start    = 1'b1;
        @(negedge clk);
        wait_done(cyc);
        chk("full latency", cyc, 17);
        chk("full count", cleared_count, 64);
        chk("full mask", clear_mask, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("full board_out", board_out, 0);
        if (SCORE_ON) exp_score = exp_score + 16'd96;
        chk("full score1", score, exp_score);
        @(negedge clk);
        chk("full restart busy", busy, 1);
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("full back2back", cyc, 18);
        start = 1'b0;
        chk("full count2", cleared_count, 64);
        if (SCORE_ON) exp_score = exp_score + 16'd96;
        chk("full score2", score, exp_score);
        @(negedge clk);
        chk("full stop", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/match_eliminate.md
Name: match_eliminate

Overview:
- Upstream neighbour of the gravity/refresh stage in the match-3 logic path.
- On `start`, snapshots the current board and finds every horizontal or vertical run of at least MIN_RUN equal, non-empty pieces.
- Outputs a board with all matched cells set to empty (0), plus a clear mask and a count. The refresh stage then compacts and refills that board.

Parameters:
- N, 8: board dimension (N x N cells).
- W, 3: bits per cell; value 0 = empty, 1..2^W-1 = piece colour.
- MIN_RUN, 3: minimum run length that is eliminated.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request one elimination pass; sampled only in IDLE.
- board_in  input  N*N*W  current board; cell (r,c) at bits [(r*N+c)*W +: W]; row 0 = top, col 0 = left.
- busy  output  1  high while a pass is in progress.
- done  output  1  one-cycle pulse; result outputs are valid from this cycle on.
- board_out  output  N*N*W  board_in snapshot with matched cells forced to 0; same packing as board_in.
- clear_mask  output  N*N  bit r*N+c set when cell (r,c) was eliminated.
- match_found  output  1  clear_mask is non-zero.
- cleared_count  output  7  number of set bits in clear_mask (0..64).
- score  output  16  accumulated score (see Optional Feature).

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - busy, done, match_found = 0.
  - board_out, clear_mask, cleared_count, score = 0.
  - Internal snapshot and mask are cleared.
- FSM states: IDLE -> SCAN_H -> SCAN_V -> COMMIT -> IDLE.
- IDLE:
  - On an edge with start=1: latch board_in into the snapshot, clear the internal mask, set busy=1, go to SCAN_H with index 0.
- SCAN_H: one row per cycle, index 0..N-1.
  - For the indexed row, mark every cell belonging to a maximal run of length >= MIN_RUN of equal non-zero values.
  - Marks are OR-ed into the internal mask. After row N-1, go to SCAN_V with index 0.
- SCAN_V: same rule, one column per cycle. After column N-1, go to COMMIT.
- COMMIT (one cycle): at the edge leaving COMMIT, register the results and return to IDLE.
  - board_out = snapshot with masked cells set to 0.
  - clear_mask = mask; cleared_count = popcount(mask); match_found = |mask.
  - done = 1 for exactly one cycle; busy = 0 on the same edge.
- Latency:
  - Start accepted at edge E0.
  - busy is high from E0 to E(2N+1).
  - done is high in the cycle after E(2N+1); for N=8 that is the edge 17 cycles after E0.
- Result outputs hold their values until the next COMMIT or a reset.
- A cell in both a horizontal and a vertical run is counted once (L/T/+ shapes).
- Runs longer than MIN_RUN (4, 5, ... N) are cleared entirely.
- Empty cells (0) never match, even in runs of zeros.
- Runs are bounded by the board edge; there is no wrap-around between row ends or column ends.
- board_in changes after E0 have no effect on the pass in flight.
- start while busy is ignored; no queuing.
- start held high: a new pass begins on the first edge back in IDLE, which is the cycle done is high.
- Reset asserted mid-pass aborts the pass: no done pulse and no partial output update.
- cleared_count width is fixed at 7; N > 11 is not supported.

Optional Feature:
- Macro: MATCH_SCORE_EN.
- Defined: at each COMMIT, score += cleared_count + bonus.
  - bonus = 2 for each maximal run of length >= MIN_RUN+1 found in the pass.
  - score saturates at 16'hFFFF; it is cleared only by rst.
- Undefined: score is tied to 0. No run counter or adder is built. All other behaviour is identical.

Test Plan:
- Reset mid-pass:
  - Stimulus: assert rst during SCAN_V.
  - Response: all outputs 0 immediately; no done pulse; the next start runs a full 17-cycle pass.
- Single horizontal run:
  - Stimulus: row 2, cols 3..5 = 3'd4; rest a checkerboard of 1/2 with no runs.
  - Response: done 17 cycles after start; clear_mask = bits 19,20,21; cleared_count = 3; board_out zero at those cells, all else unchanged.
- Overlapping runs (T-shape):
  - Stimulus: row 0, cols 0..4 = 5 and col 2, rows 0..3 = 5; rest no runs.
  - Response: cleared_count = 8; score += 8 + 2 + 2 = 12 with MATCH_SCORE_EN, score stays 0 without it.
- No-match and empty-run cases:
  - Stimulus: board with no runs; separately, an entire row of 0.
  - Response: match_found = 0, cleared_count = 0, board_out == board_in.
- Edge and wrap, with busy handling:
  - Stimulus: row 0 cols 6,7 = 3 and row 1 col 0 = 3 (no wrap run); start pulsed again while busy.
  - Response: no clear at those cells; the second start is ignored; exactly one done pulse.
- Full board:
  - Stimulus: every cell = 7, start held high continuously.
  - Response: cleared_count = 64; board_out = 0; back-to-back passes start on each done cycle.
  - With MATCH_SCORE_EN: 16 runs of length 8 give score += 64 + 32 = 96 per pass.
